// File: rtl/ram_write_arbiter.sv
// Round-robin arbiter for the single RAM write port, with registered write outputs.
// Define RAM_ARB_BURST_LOCK_EN to let a requester hold the port until its last beat.
module ram_write_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH         = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              last,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            WR_Enable,
  output logic [ADDRESS_WIDTH-1:0]        address_WR,
  output logic [DATA_WIDTH-1:0]           dataIn,
  output logic [2:0]                      owner,
  output logic                            locked,
  output logic                            err_oob
);

`ifdef RAM_ARB_BURST_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state;
  logic [2:0]               rr_ptr;
  logic [2:0]               win;
  logic                     win_valid;
  logic                     win_last;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_data;

  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    if (RST) begin
      if (state == LOCKED) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (req[i] && 3'(i) == owner) begin
            win       = 3'(i);
            win_valid = 1'b1;
          end
      end else begin
        // Descending offsets so the requester closest to rr_ptr is written last and wins.
        for (int k = NUM_REQ-1; k >= 0; k--)
          for (int i = 0; i < NUM_REQ; i++)
            if (req[i] && i == (int'(rr_ptr) + k) % NUM_REQ) begin
              win       = 3'(i);
              win_valid = 1'b1;
            end
      end
    end
  end

  always_comb begin
    gnt      = '0;
    win_last = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_valid && 3'(i) == win) begin
        gnt[i]   = 1'b1;
        win_last = last[i] | ~LOCK_EN;
        win_addr = addr_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        win_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      locked     <= 1'b0;
      WR_Enable  <= 1'b0;
      address_WR <= '0;
      dataIn     <= '0;
      err_oob    <= 1'b0;
    end else begin
      WR_Enable <= 1'b0;
      if (win_valid) begin
        owner <= win;
        if ({1'b0, win_addr} < DEPTH_W) begin
          WR_Enable  <= 1'b1;
          address_WR <= win_addr;
          dataIn     <= win_data;
        end else begin
          err_oob <= 1'b1;
        end
        if (win_last) begin
          state  <= IDLE;
          locked <= 1'b0;
          rr_ptr <= (win == 3'(NUM_REQ-1)) ? 3'd0 : win + 3'd1;
        end else begin
          state  <= LOCKED;
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Directed self-checking bench for ram_write_arbiter (NUM_REQ=3, DEPTH=16).
module tb_ram_write_arbiter;
  localparam int NR = 3;
  localparam int AW = 13;
  localparam int DW = 64;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    last = '0;
  logic [NR*AW-1:0] addr_in = '0;
  logic [NR*DW-1:0] data_in = '0;
  logic [NR-1:0]    gnt;
  logic             WR_Enable;
  logic [AW-1:0]    address_WR;
  logic [DW-1:0]    dataIn;
  logic [2:0]       owner;
  logic             locked;
  logic             err_oob;

  int checks = 0;
  int errors = 0;

  ram_write_arbiter #(.NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .req(req), .last(last), .addr_in(addr_in), .data_in(data_in),
    .gnt(gnt), .WR_Enable(WR_Enable), .address_WR(address_WR), .dataIn(dataIn),
    .owner(owner), .locked(locked), .err_oob(err_oob)
  );

  always #5 CLK = ~CLK;

  task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    addr_in[i*AW +: AW] = a;
    data_in[i*DW +: DW] = d;
    last[i] = l;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    req = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b0;
    req = 3'b111;
    last = 3'b111;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (WR_Enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", WR_Enable); end
    checks++; if (address_WR !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", address_WR); end
    checks++; if (dataIn !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dataIn); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL reset_oob got %b want 0", err_oob); end
    @(negedge CLK);
    req = '0;
    RST = 1'b1;
  endtask

  task automatic test_single();
    @(negedge CLK);
    req = 3'b001;
    set_beat(0, 13'd5, 64'hAA, 1'b1);
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b want 001", gnt); end
    @(posedge CLK); #1;
    checks++; if (WR_Enable !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", WR_Enable); end
    checks++; if (address_WR !== 13'd5) begin errors++; $display("FAIL single_addr got %0d want 5", address_WR); end
    checks++; if (dataIn !== 64'hAA) begin errors++; $display("FAIL single_data got %h want aa", dataIn); end
    @(negedge CLK);
    req = '0;
    @(posedge CLK); #1;
    checks++; if (WR_Enable !== 1'b0) begin errors++; $display("FAIL single_we_after got %b want 0", WR_Enable); end
    checks++; if (address_WR !== 13'd5) begin errors++; $display("FAIL single_addr_hold got %0d want 5", address_WR); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [AW-1:0] exp_a [6] = '{13'd8, 13'd9, 13'd10, 13'd8, 13'd9, 13'd10};
    do_reset();
    for (int i = 0; i < NR; i++) set_beat(i, 13'(8 + i), 64'(100 + i), 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      req = 3'b111;
      #1;
      checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", c, gnt, exp_g[c]); end
      @(posedge CLK); #1;
      checks++; if (WR_Enable !== 1'b1 || address_WR !== exp_a[c])
        begin errors++; $display("FAIL rr_write[%0d] got we=%b addr=%0d want we=1 addr=%0d", c, WR_Enable, address_WR, exp_a[c]); end
    end
    @(negedge CLK);
    req = '0;
  endtask

  task automatic test_oob();
    @(negedge CLK);
    req = 3'b100;
    set_beat(2, 13'd16, 64'h1234, 1'b1);
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL oob_gnt got %b want 100", gnt); end
    @(posedge CLK); #1;
    checks++; if (WR_Enable !== 1'b0) begin errors++; $display("FAIL oob_we got %b want 0", WR_Enable); end
    checks++; if (address_WR !== 13'd10) begin errors++; $display("FAIL oob_addr_hold got %0d want 10", address_WR); end
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_err got %b want 1", err_oob); end
    @(negedge CLK);
    set_beat(2, 13'd15, 64'h55, 1'b1);
    @(posedge CLK); #1;
    checks++; if (WR_Enable !== 1'b1 || address_WR !== 13'd15)
      begin errors++; $display("FAIL oob_edge got we=%b addr=%0d want we=1 addr=15", WR_Enable, address_WR); end
    @(negedge CLK);
    req = '0;
    @(posedge CLK); #1;
    checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b want 1", err_oob); end
  endtask

`ifdef RAM_ARB_BURST_LOCK_EN
  task automatic test_burst();
    do_reset();
    #1;
    checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL burst_oob_cleared got %b want 0", err_oob); end
    req = 3'b001;
    set_beat(0, 13'd1, 64'h1, 1'b1);
    @(negedge CLK);
    req = 3'b011;
    set_beat(0, 13'd9, 64'h9, 1'b1);
    set_beat(1, 13'd2, 64'h20, 1'b0);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt1 got %b want 010", gnt); end
    @(posedge CLK); #1;
    checks++; if (locked !== 1'b1 || owner !== 3'd1) begin errors++; $display("FAIL burst_lock1 got locked=%b owner=%0d want 1 1", locked, owner); end
    @(negedge CLK);
    set_beat(1, 13'd3, 64'h30, 1'b0);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt2 got %b want 010", gnt); end
    @(posedge CLK); #1;
    checks++; if (address_WR !== 13'd3) begin errors++; $display("FAIL burst_addr2 got %0d want 3", address_WR); end
    @(negedge CLK);
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL burst_stall_gnt got %b want 000", gnt); end
    @(posedge CLK); #1;
    checks++; if (locked !== 1'b1 || WR_Enable !== 1'b0) begin errors++; $display("FAIL burst_stall got locked=%b we=%b want 1 0", locked, WR_Enable); end
    @(negedge CLK);
    req = 3'b011;
    set_beat(1, 13'd4, 64'h40, 1'b1);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL burst_gnt3 got %b want 010", gnt); end
    @(posedge CLK); #1;
    checks++; if (locked !== 1'b0 || address_WR !== 13'd4) begin errors++; $display("FAIL burst_end got locked=%b addr=%0d want 0 4", locked, address_WR); end
    @(negedge CLK);
    req = 3'b001;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL burst_next got %b want 001", gnt); end
    @(negedge CLK);
    req = '0;
  endtask
`else
  task automatic test_no_lock();
    logic [NR-1:0] exp_g [4] = '{3'b001, 3'b010, 3'b001, 3'b010};
    do_reset();
    set_beat(0, 13'd1, 64'h1, 1'b0);
    set_beat(1, 13'd2, 64'h2, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      req = 3'b011;
      #1;
      checks++; if (gnt !== exp_g[c]) begin errors++; $display("FAIL nolock_gnt[%0d] got %b want %b", c, gnt, exp_g[c]); end
      @(posedge CLK); #1;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL nolock_locked[%0d] got %b want 0", c, locked); end
    end
    @(negedge CLK);
    req = '0;
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b010;
    set_beat(1, 13'd1, 64'h11, 1'b1);
    @(negedge CLK);
    set_beat(1, 13'd2, 64'h22, 1'b0);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt got %b want 010", gnt); end
    @(posedge CLK); #1;
`ifdef RAM_ARB_BURST_LOCK_EN
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL midrst_locked_pre got %b want 1", locked); end
`endif
    @(negedge CLK);
    RST = 1'b0;
    set_beat(1, 13'd3, 64'h33, 1'b0);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL midrst_gnt_in_reset got %b want 000", gnt); end
    @(posedge CLK); #1;
    checks++; if (WR_Enable !== 1'b0 || locked !== 1'b0 || owner !== 3'd0)
      begin errors++; $display("FAIL midrst_state got we=%b locked=%b owner=%0d want 0 0 0", WR_Enable, locked, owner); end
    @(negedge CLK);
    RST = 1'b1;
    req = 3'b110;
    set_beat(1, 13'd6, 64'h66, 1'b1);
    set_beat(2, 13'd7, 64'h77, 1'b1);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_rr got %b want 010", gnt); end
    @(posedge CLK); #1;
    checks++; if (owner !== 3'd1 || address_WR !== 13'd6) begin errors++; $display("FAIL midrst_write got owner=%0d addr=%0d want 1 6", owner, address_WR); end
    @(negedge CLK);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_oob();
`ifdef RAM_ARB_BURST_LOCK_EN
    test_burst();
`else
    test_no_lock();
`endif
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
